// File: rtl/clock_alarm.sv
// clock_alarm: programmable alarm with snooze, ring auto-timeout and dismiss.
// Define CLOCK_ALARM_CHIME_EN to add the CHIME output (hourly chime pulse).
module clock_alarm #(
  parameter int SNOOZE_MIN  = 9,
  parameter int RING_CYCLES = 30,
  parameter int HOUR_CNT    = 24,
  parameter int MIN_CNT     = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] SEC,
  input  logic [5:0] MIN,
  input  logic [4:0] HOUR,
  input  logic       SET_EN,
  input  logic [4:0] SET_HOUR,
  input  logic [5:0] SET_MIN,
  input  logic       ARM,
  input  logic       SNOOZE,
  input  logic       DISMISS,
  output logic [4:0] ALARM_HOUR,
  output logic [5:0] ALARM_MIN,
  output logic       RINGING,
`ifdef CLOCK_ALARM_CHIME_EN
  output logic       SNOOZED,
  output logic       CHIME
`else
  output logic       SNOOZED
`endif
);

  localparam int CNT_W = $clog2(RING_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE
  } state_t;

  state_t           r_state, w_nextState;
  logic [4:0]       r_alarmHour, r_tgtHour, w_nextTgtHour;
  logic [5:0]       r_alarmMin, r_tgtMin, w_nextTgtMin;
  logic [CNT_W-1:0] r_ringCnt, w_nextRingCnt;
  logic             r_ringing, r_snoozed;
  logic             w_setValid, w_match, w_timeout;
  logic [6:0]       w_snzMinSum;
  logic [5:0]       w_snzHourSum;
  logic [5:0]       w_snzMin;
  logic [4:0]       w_snzHour;

  assign w_setValid = SET_EN && (32'(SET_HOUR) < HOUR_CNT) && (32'(SET_MIN) < MIN_CNT);
  assign w_match    = (HOUR == r_tgtHour) && (MIN == r_tgtMin) && (SEC == 6'd0);
  assign w_timeout  = (r_ringCnt == CNT_W'(RING_CYCLES - 1));

  // Snooze target: current time plus SNOOZE_MIN, minute carry into a wrapping hour
  always_comb begin
    w_snzMinSum = 7'(MIN) + 7'(SNOOZE_MIN);
    if (w_snzMinSum >= 7'(MIN_CNT)) begin
      w_snzMin     = 6'(w_snzMinSum - 7'(MIN_CNT));
      w_snzHourSum = 6'(HOUR) + 6'd1;
    end else begin
      w_snzMin     = 6'(w_snzMinSum);
      w_snzHourSum = 6'(HOUR);
    end
    w_snzHour = (w_snzHourSum >= 6'(HOUR_CNT)) ? 5'd0 : 5'(w_snzHourSum);
  end

  // A valid SET_EN beats everything, then ARM low, then the per-state events
  always_comb begin
    w_nextState   = r_state;
    w_nextTgtHour = r_tgtHour;
    w_nextTgtMin  = r_tgtMin;
    w_nextRingCnt = r_ringCnt;
    if (w_setValid) begin
      w_nextState   = S_IDLE;
      w_nextTgtHour = SET_HOUR;
      w_nextTgtMin  = SET_MIN;
    end else if (!ARM) begin
      w_nextState   = S_IDLE;
      w_nextTgtHour = r_alarmHour;
      w_nextTgtMin  = r_alarmMin;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_match) begin
            w_nextState   = S_RING;
            w_nextRingCnt = '0;
          end
        end
        S_RING: begin
          if (DISMISS) begin
            w_nextState   = S_IDLE;
            w_nextTgtHour = r_alarmHour;
            w_nextTgtMin  = r_alarmMin;
          end else if (SNOOZE) begin
            w_nextState   = S_SNOOZE;
            w_nextTgtHour = w_snzHour;
            w_nextTgtMin  = w_snzMin;
          end else if (w_timeout) begin
            w_nextState   = S_IDLE;
            w_nextTgtHour = r_alarmHour;
            w_nextTgtMin  = r_alarmMin;
          end else begin
            w_nextRingCnt = r_ringCnt + CNT_W'(1);
          end
        end
        S_SNOOZE: begin
          if (DISMISS) begin
            w_nextState   = S_IDLE;
            w_nextTgtHour = r_alarmHour;
            w_nextTgtMin  = r_alarmMin;
          end else if (w_match) begin
            w_nextState   = S_RING;
            w_nextRingCnt = '0;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_alarmHour <= '0;
      r_alarmMin  <= '0;
      r_tgtHour   <= '0;
      r_tgtMin    <= '0;
      r_ringCnt   <= '0;
      r_ringing   <= 1'b0;
      r_snoozed   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_tgtHour <= w_nextTgtHour;
      r_tgtMin  <= w_nextTgtMin;
      r_ringCnt <= w_nextRingCnt;
      r_ringing <= (w_nextState == S_RING);
      r_snoozed <= (w_nextState == S_SNOOZE);
      if (w_setValid) begin
        r_alarmHour <= SET_HOUR;
        r_alarmMin  <= SET_MIN;
      end
    end
  end

  assign ALARM_HOUR = r_alarmHour;
  assign ALARM_MIN  = r_alarmMin;
  assign RINGING    = r_ringing;
  assign SNOOZED    = r_snoozed;

`ifdef CLOCK_ALARM_CHIME_EN
  logic r_chime;

  // Top-of-hour pulse, held off for any cycle in which RINGING will be high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_chime <= 1'b0;
    end else begin
      r_chime <= (MIN == 6'd0) && (SEC == 6'd0) && (w_nextState != S_RING);
    end
  end

  assign CHIME = r_chime;
`endif

endmodule

// File: tb/tb_clock_alarm.sv
// tb_clock_alarm: directed vector table, hand-written corner sequences and
// randomized traffic checked against a time-arithmetic reference model.
module tb_clock_alarm;

  localparam int SNOOZE_MIN  = 9;
  localparam int RING_CYCLES = 30;
  localparam int HOUR_CNT    = 24;
  localparam int MIN_CNT     = 60;

  logic       CLK = 1'b0;
  logic       RST;
  logic [5:0] SEC, MIN, SET_MIN;
  logic [4:0] HOUR, SET_HOUR;
  logic       SET_EN, ARM, SNOOZE, DISMISS;
  logic [4:0] ALARM_HOUR;
  logic [5:0] ALARM_MIN;
  logic       RINGING, SNOOZED;
`ifdef CLOCK_ALARM_CHIME_EN
  logic       CHIME;
`endif

  int testsRun  = 0;
  int testsFail = 0;

  // Reference model state, kept as plain integers
  int mAlH, mAlM, mTgtH, mTgtM, mAge;
  bit mRing, mSnz, mChime;

  typedef struct {
    bit se; int sh; int sm; bit ar; bit sn; bit di;
    int h; int m; int s;
    bit er; bit es; int eah; int eam;
  } vec_t;

  vec_t vecs[$];

  clock_alarm dut (
    .CLK(CLK), .RST(RST), .SEC(SEC), .MIN(MIN), .HOUR(HOUR),
    .SET_EN(SET_EN), .SET_HOUR(SET_HOUR), .SET_MIN(SET_MIN),
    .ARM(ARM), .SNOOZE(SNOOZE), .DISMISS(DISMISS),
    .ALARM_HOUR(ALARM_HOUR), .ALARM_MIN(ALARM_MIN),
    .RINGING(RINGING),
`ifdef CLOCK_ALARM_CHIME_EN
    .SNOOZED(SNOOZED),
    .CHIME(CHIME)
`else
    .SNOOZED(SNOOZED)
`endif
  );

  always #5 CLK = ~CLK;

  function automatic vec_t mk(bit se, int sh, int sm, bit ar, bit sn, bit di,
                              int h, int m, int s, bit er, bit es, int eah, int eam);
    vec_t v;
    v.se = se; v.sh = sh; v.sm = sm; v.ar = ar; v.sn = sn; v.di = di;
    v.h = h; v.m = m; v.s = s; v.er = er; v.es = es; v.eah = eah; v.eam = eam;
    return v;
  endfunction

  task automatic resetModel();
    mAlH = 0; mAlM = 0; mTgtH = 0; mTgtM = 0; mAge = 0;
    mRing = 0; mSnz = 0; mChime = 0;
  endtask

  task automatic modelIdle();
    mRing = 0; mSnz = 0; mTgtH = mAlH; mTgtM = mAlM;
  endtask

  task automatic modelStep(bit se, int sh, int sm, bit ar, bit sn, bit di, int h, int m, int s);
    bit match;
    int t;
    match = (h == mTgtH) && (m == mTgtM) && (s == 0);
    if (se && sh < HOUR_CNT && sm < MIN_CNT) begin
      mAlH = sh; mAlM = sm; mTgtH = sh; mTgtM = sm; mRing = 0; mSnz = 0;
    end else if (!ar) begin
      modelIdle();
    end else if (mRing) begin
      if (di) modelIdle();
      else if (sn) begin
        mRing = 0; mSnz = 1;
        t = (h * MIN_CNT + m + SNOOZE_MIN) % (HOUR_CNT * MIN_CNT);
        mTgtH = t / MIN_CNT; mTgtM = t % MIN_CNT;
      end else if (mAge == RING_CYCLES) modelIdle();
      else mAge++;
    end else if (mSnz) begin
      if (di) modelIdle();
      else if (match) begin mRing = 1; mSnz = 0; mAge = 1; end
    end else if (match) begin
      mRing = 1; mAge = 1;
    end
    mChime = (m == 0) && (s == 0) && !mRing;
  endtask

  task automatic applyStimulus(bit se, int sh, int sm, bit ar, bit sn, bit di, int h, int m, int s);
    SET_EN = se; SET_HOUR = 5'(sh); SET_MIN = 6'(sm);
    ARM = ar; SNOOZE = sn; DISMISS = di;
    HOUR = 5'(h); MIN = 6'(m); SEC = 6'(s);
    @(posedge CLK);
    modelStep(se, sh, sm, ar, sn, di, h, m, s);
    #1;
  endtask

  task automatic checkOutput(string name, bit er, bit es, int eah, int eam);
    testsRun++;
    if (RINGING !== er || SNOOZED !== es || ALARM_HOUR !== 5'(eah) || ALARM_MIN !== 6'(eam)) begin
      testsFail++;
      $display("[TB] FAIL %s: got RINGING=%0b SNOOZED=%0b ALARM=%0d:%0d, expected %0b %0b %0d:%0d",
               name, RINGING, SNOOZED, ALARM_HOUR, ALARM_MIN, er, es, eah, eam);
    end
  endtask

`ifdef CLOCK_ALARM_CHIME_EN
  task automatic checkChime(string name, bit ec);
    testsRun++;
    if (CHIME !== ec) begin
      testsFail++;
      $display("[TB] FAIL %s: got CHIME=%0b, expected %0b", name, CHIME, ec);
    end
  endtask
`endif

  // Ring started at 07:30; it must stay up for exactly RING_CYCLES cycles in total
  task automatic timeoutSequence();
    for (int k = 1; k < RING_CYCLES; k++) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 7, 30, 1);
      checkOutput($sformatf("ringHold%0d", k), 1, 0, 7, 30);
    end
    applyStimulus(0, 0, 0, 1, 0, 0, 7, 30, 1);
    checkOutput("ringTimeout", 0, 0, 7, 30);
  endtask

  initial begin
    bit se, ar, sn, di;
    int sh, sm, h, m, s;

    RST = 1'b1;
    SET_EN = 0; SET_HOUR = 0; SET_MIN = 0; ARM = 0; SNOOZE = 0; DISMISS = 0;
    HOUR = 0; MIN = 0; SEC = 1;
    resetModel();
    #12 RST = 1'b0;
    #1;
    checkOutput("reset", 0, 0, 0, 0);
`ifdef CLOCK_ALARM_CHIME_EN
    checkChime("resetChime", 0);
`endif

    //            se sh sm  ar sn di  h  m  s   er es eah eam
    vecs.push_back(mk(1, 7, 30, 0, 0, 0, 7, 0, 0, 0, 0, 7, 30));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7, 29, 59, 0, 0, 7, 30));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 7, 30, 0, 1, 0, 7, 30));
    vecs.push_back(mk(1, 23, 55, 1, 0, 0, 12, 0, 5, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 23, 55, 0, 1, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 23, 55, 3, 0, 1, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 23, 59, 0, 0, 1, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 3, 0, 0, 1, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4, 0, 1, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, 4, 1, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 4, 0, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 23, 55, 0, 1, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 23, 55));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 23, 55));
    vecs.push_back(mk(1, 24, 10, 0, 0, 0, 0, 0, 3, 0, 0, 23, 55));
    vecs.push_back(mk(1, 10, 60, 0, 0, 0, 0, 0, 4, 0, 0, 23, 55));
    vecs.push_back(mk(1, 23, 55, 1, 0, 0, 23, 55, 0, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 23, 55, 0, 1, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 23, 55, 1, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 23, 55, 2, 0, 0, 23, 55));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 23, 55, 3, 0, 0, 23, 55));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].se, vecs[i].sh, vecs[i].sm, vecs[i].ar, vecs[i].sn, vecs[i].di,
                    vecs[i].h, vecs[i].m, vecs[i].s);
      checkOutput($sformatf("row%0d", i), vecs[i].er, vecs[i].es, vecs[i].eah, vecs[i].eam);
`ifdef CLOCK_ALARM_CHIME_EN
      checkChime($sformatf("row%0dChime", i), mChime);
`endif
      if (i == 2) timeoutSequence();
    end

`ifdef CLOCK_ALARM_CHIME_EN
    applyStimulus(1, 10, 0, 0, 0, 0, 9, 59, 59);
    checkChime("chimeBefore", 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 10, 0, 0);
    checkChime("chimeTop", 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 10, 0, 1);
    checkChime("chimeOnce", 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 10, 0, 0);
    checkOutput("chimeRingStart", 1, 0, 10, 0);
    checkChime("chimeRing", 0);
    applyStimulus(0, 0, 0, 1, 0, 1, 10, 0, 2);
    checkOutput("chimeDismiss", 0, 0, 10, 0);
`endif

    // Random traffic, biased so the clock often sits on the current target
    for (int n = 0; n < 2000; n++) begin
      se = ($urandom_range(31) == 0);
      sh = int'($urandom_range(25));
      sm = int'($urandom_range(62));
      ar = ($urandom_range(63) != 0);
      sn = ($urandom_range(31) == 0);
      di = ($urandom_range(31) == 0);
      if ($urandom_range(1) == 1) begin
        h = mTgtH; m = mTgtM;
      end else begin
        h = int'($urandom_range(23));
        m = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(59));
      end
      s = ($urandom_range(1) == 1) ? 0 : int'($urandom_range(59));
      applyStimulus(se, sh, sm, ar, sn, di, h, m, s);
      checkOutput($sformatf("rand%0d", n), mRing, mSnz, mAlH, mAlM);
`ifdef CLOCK_ALARM_CHIME_EN
      checkChime($sformatf("rand%0dChime", n), mChime);
`endif
    end

    // Reset asserted between clock edges must clear outputs immediately
    applyStimulus(1, 7, 30, 1, 0, 0, 7, 30, 0);
    checkOutput("setBeatsMatch2", 0, 0, 7, 30);
    applyStimulus(0, 0, 0, 1, 0, 0, 7, 30, 0);
    checkOutput("preReset", 1, 0, 7, 30);
    #2 RST = 1'b1;
    #1;
    checkOutput("asyncReset", 0, 0, 0, 0);
`ifdef CLOCK_ALARM_CHIME_EN
    checkChime("asyncResetChime", 0);
`endif
    #10 RST = 1'b0;
    resetModel();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
    $finish;
  end

endmodule
